// File: rtl/pc_seq_if.sv
// Fetch port bundle: instruction-memory read channel, decode-side output buffer
// and the redirect input from decode.
interface pc_seq_if #(
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              d_ready;
    logic              redirect;
    logic [31:0]       redirect_target;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_rvalid, imem_rdata, d_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_rvalid, imem_rdata, d_ready, redirect, redirect_target
    );
endinterface

// File: rtl/pc_seq.sv
// Fetch PC sequencer: one outstanding imem read at a time, a one-entry buffer
// towards decode, and branch/jump redirects applied after a single delay slot.
module pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DATA_W   = 32
) (
    input logic      clk,
    input logic      reset,
    pc_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

    state_t            state;
    logic              run;
    logic [31:0]       fetch_pc;
    logic [31:0]       req_addr;
    logic              pend;
    logic [31:0]       pend_tgt;
    logic              buf_vld;
    logic [31:0]       buf_pc;
    logic [DATA_W-1:0] buf_instr;

    logic              xfer;
    logic              issue;
    logic              ret_keep;
    logic              dslot_held;
    logic              rd_after;
    logic [31:0]       tgt;

    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    assign xfer     = buf_vld && bus.d_ready;
    assign issue    = run && (state == IDLE) && (!buf_vld || xfer);
    assign ret_keep = (state == BUSY) && bus.imem_rvalid;
    // The delay slot is in the buffer (or landing there now) unless it is still in flight.
    assign dslot_held = ret_keep || buf_vld;
    // A read stays in flight past this edge if one is issued now or one is not yet back.
    assign rd_after = issue || ((state != IDLE) && !bus.imem_rvalid);
    assign tgt      = word_align(bus.redirect_target);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = (state == IDLE) ? fetch_pc : req_addr;
    assign bus.if_valid  = buf_vld;
    assign bus.if_pc     = buf_pc;
    assign bus.if_instr  = buf_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            run       <= 1'b0;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            pend      <= 1'b0;
            pend_tgt  <= '0;
            buf_vld   <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else begin
            run <= 1'b1;
            if (issue) begin
                req_addr <= fetch_pc;
            end

            if (ret_keep) begin
                buf_vld   <= 1'b1;
                buf_pc    <= fetch_pc;
                buf_instr <= bus.imem_rdata;
            end else if (xfer) begin
                buf_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (issue) state <= BUSY;
                end
                BUSY: begin
                    if (bus.imem_rvalid) begin
                        state    <= IDLE;
                        fetch_pc <= pend ? pend_tgt : seq_next(fetch_pc);
                        pend     <= 1'b0;
                    end
                end
                SQUASH: begin
                    if (bus.imem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Redirect is evaluated against the buffer as it stands after any return.
            if (run && bus.redirect) begin
                if (dslot_held) begin
                    fetch_pc <= tgt;
                    if (rd_after) state <= SQUASH;
                end else begin
                    pend     <= 1'b1;
                    pend_tgt <= tgt;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_seq.sv
// Randomized bench for pc_seq: memory slave with variable latency, a decode
// model that branches at random, and an architectural PC-stream reference.
module tb_pc_seq;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_seq_if #(.DATA_W(32)) bus ();
    pc_seq #(.RESET_PC(RESET_PC), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Program image: each word is a fixed scramble of its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8;
        return {r[31:2], 2'b00};
    endfunction

    bit          m_busy;
    logic [31:0] m_addr;
    int          m_rem;
    int          lat_lo, lat_hi;
    int          dr_mode;
    int          br_pct;
    bit          lat_chk;
    bit          prev_rv;
    logic [31:0] prev_addr;

    logic [31:0] exp_pc;
    bit          after_br;
    int          br_wait;
    logic [31:0] br_tgt;
    bit          force_br;
    int          force_wait;
    logic [31:0] force_tgt;

    int          cyc;
    int          n_del;
    int          n_req;
    int          idle_cyc;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] del_log[$];

    task automatic model_init();
        m_busy   = 1'b0;
        m_addr   = '0;
        m_rem    = 0;
        prev_rv  = 1'b0;
        exp_pc   = RESET_PC;
        after_br = 1'b0;
        br_wait  = 0;
        force_br = 1'b0;
        cyc      = 0;
        idle_cyc = 0;
        req_log.delete();
        req_cyc.delete();
        del_log.delete();
    endtask

    // Decode accepted an instruction: check it against the architectural stream.
    task automatic deliver(input logic [31:0] pc, input logic [31:0] ins);
        check_eq("deliver_pc", pc, exp_pc);
        check_eq("deliver_instr", ins, mem_word(pc));
        n_del++;
        idle_cyc = 0;
        del_log.push_back(pc);
        if (after_br) begin
            exp_pc   = br_tgt;
            after_br = 1'b0;
        end else begin
            exp_pc = pc + 32'd4;
            if (force_br || ($urandom_range(0, 99) < br_pct)) begin
                after_br = 1'b1;
                br_wait  = force_br ? force_wait : $urandom_range(1, 3);
                br_tgt   = force_br ? force_tgt : rand_tgt();
                force_br = 1'b0;
            end
        end
    endtask

    task automatic step();
        bit rv;
        bit xf;
        @(negedge clk);
        cyc++;
        rv = m_busy && (m_rem == 1);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_word(m_addr) : $urandom();
        bus.redirect    = 1'b0;
        if (br_wait == 1) begin
            bus.redirect        = 1'b1;
            bus.redirect_target = br_tgt | 32'($urandom_range(0, 3));
        end
        if (br_wait > 1)       bus.d_ready = 1'b0;
        else if (dr_mode == 1) bus.d_ready = 1'b1;
        else if (dr_mode == 2) bus.d_ready = 1'b0;
        else                   bus.d_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (lat_chk && prev_rv) begin
            check_eq("load_valid", 32'(bus.if_valid), 32'd1);
            check_eq("load_pc", bus.if_pc, prev_addr);
        end
        prev_rv   = rv;
        prev_addr = m_addr;
        if (m_busy) begin
            check_eq("addr_stable", bus.imem_addr, m_addr);
            check_eq("one_outstanding", 32'(bus.imem_req), 32'd0);
        end
        xf = bus.if_valid && bus.d_ready;
        if (br_wait > 0) br_wait--;
        if (xf) deliver(bus.if_pc, bus.if_instr);
        if (rv) m_busy = 1'b0;
        else if (m_busy) m_rem--;
        if (bus.imem_req) begin
            check_eq("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            n_req++;
            req_log.push_back(bus.imem_addr);
            req_cyc.push_back(cyc);
            m_busy = 1'b1;
            m_addr = bus.imem_addr;
            m_rem  = $urandom_range(lat_lo, lat_hi);
        end
        idle_cyc++;
        if (idle_cyc > 40) begin
            check_eq("progress_watchdog", 32'(idle_cyc), 32'd0);
            idle_cyc = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
        check_eq({tag, "_if_pc"}, bus.if_pc, 32'd0);
        check_eq({tag, "_if_instr"}, bus.if_instr, 32'd0);
        check_eq({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        check_eq({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        bus.d_ready     = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        model_init();
    endtask

    task automatic run_phase(input int ncyc, input string name);
        int d0;
        d0 = n_del;
        for (int i = 0; i < ncyc; i++) step();
        check_eq({name, "_progress"}, 32'(n_del > d0), 32'd1);
    endtask

    task automatic check_first3(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c);
        check_eq({name, "_ndel"}, 32'(del_log.size() >= 3), 32'd1);
        if (del_log.size() >= 3) begin
            check_eq({name, "_del0"}, del_log[0], a);
            check_eq({name, "_del1"}, del_log[1], b);
            check_eq({name, "_del2"}, del_log[2], c);
        end
    endtask

    task automatic reset_mid_read();
        int guard;
        guard   = 0;
        lat_lo  = 3;
        lat_hi  = 3;
        dr_mode = 1;
        br_pct  = 0;
        lat_chk = 1'b0;
        while (!(m_busy && m_rem >= 2) && guard < 30) begin
            step();
            guard++;
        end
        check_eq("rmr_outstanding", 32'(m_busy), 32'd1);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("rmr");
        @(negedge clk);
        reset           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.d_ready     = 1'b1;
        #1;
        check_eq("rmr_no_req_before_edge", 32'(bus.imem_req), 32'd0);
        model_init();
    endtask

    initial begin
        int r0;
        int d0;
        int guard;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = '0;
        bus.d_ready         = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        n_del = 0;
        n_req = 0;
        model_init();
        lat_lo  = 1;
        lat_hi  = 1;
        dr_mode = 1;
        br_pct  = 0;
        lat_chk = 1'b1;

        // Sequential fetch, 1-cycle memory, decode always ready.
        do_reset();
        repeat (7) step();
        check_eq("seq_nreq", 32'(req_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) begin
            check_eq("seq_addr0", req_log[0], 32'h0000_3000);
            check_eq("seq_addr1", req_log[1], 32'h0000_3004);
            check_eq("seq_addr2", req_log[2], 32'h0000_3008);
            check_eq("seq_cyc0", 32'(req_cyc[0]), 32'd1);
            check_eq("seq_cyc1", 32'(req_cyc[1]), 32'd3);
            check_eq("seq_cyc2", 32'(req_cyc[2]), 32'd5);
        end

        // Decode stall with a full buffer.
        dr_mode = 2;
        guard   = 0;
        while (!bus.if_valid && guard < 20) begin
            step();
            guard++;
        end
        check_eq("stall_full", 32'(bus.if_valid), 32'd1);
        r0 = n_req;
        repeat (5) step();
        check_eq("stall_no_req", 32'(n_req), 32'(r0));
        check_eq("stall_held", 32'(bus.if_valid), 32'd1);
        d0      = n_del;
        dr_mode = 1;
        step();
        check_eq("stall_one_req", 32'(n_req), 32'(r0 + 1));
        check_eq("stall_one_del", 32'(n_del), 32'(d0 + 1));
        run_phase(10, "stall_resume");

        // Branch at 0x3000, redirect while the delay slot sits in the buffer.
        lat_chk = 1'b0;
        do_reset();
        force_br = 1'b1; force_tgt = 32'h0000_4000; force_wait = 2;
        run_phase(12, "dslot_buf");
        check_first3("dslot_buf", 32'h3000, 32'h3004, 32'h4000);
        check_eq("dslot_buf_nreq", 32'(req_log.size() >= 4), 32'd1);
        if (req_log.size() >= 4) begin
            check_eq("dslot_buf_squashed", req_log[2], 32'h0000_3008);
            check_eq("dslot_buf_target", req_log[3], 32'h0000_4000);
        end

        // Redirect while the delay slot is still in flight, 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        force_br = 1'b1; force_tgt = 32'h0000_4000; force_wait = 1;
        run_phase(20, "dslot_flight");
        check_first3("dslot_flight", 32'h3000, 32'h3004, 32'h4000);
        if (req_log.size() >= 3) check_eq("dslot_flight_next", req_log[2], 32'h0000_4000);

        // Redirect in the same cycle as the delay slot returns.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        force_br = 1'b1; force_tgt = 32'h0000_4000; force_wait = 1;
        run_phase(10, "dslot_same");
        check_first3("dslot_same", 32'h3000, 32'h3004, 32'h4000);
        if (req_log.size() >= 3) check_eq("dslot_same_next", req_log[2], 32'h0000_4000);

        // Reset during an outstanding read; stale return must be dropped.
        reset_mid_read();
        run_phase(12, "rmr");
        if (req_log.size() >= 1) check_eq("rmr_first_req", req_log[0], RESET_PC);
        if (del_log.size() >= 1) check_eq("rmr_first_del", del_log[0], RESET_PC);

        // Random traffic.
        lat_lo = 1; lat_hi = 3; dr_mode = 0; br_pct = 0; lat_chk = 1'b1;
        run_phase(400, "rand_seq");
        lat_chk = 1'b0; br_pct = 25;
        run_phase(3000, "rand_branch");
        lat_lo = 1; lat_hi = 1;
        run_phase(2000, "rand_branch_lat1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
# pc_seq

Fetch-side sequencer that owns the fetch PC and issues instruction-memory reads one at a time over a request/valid handshake. Fetched words go into a one-entry output buffer handed to the decode stage. Branch and jump redirects arrive from decode, where the next-PC logic resolves them; the sequencer applies them with MIPS delay-slot semantics. It sits between the instruction memory port and the F/D pipeline register, replacing a free-running PC register.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle pulse: read request at imem_addr
- imem_addr  out  32  word address; bits [1:0] always 0; stable from request until imem_rvalid
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word, qualified by imem_rvalid
- if_valid  out  1  output buffer holds an instruction
- if_pc  out  32  PC of buffered instruction
- if_instr  out  32  buffered instruction
- d_ready  in  1  decode accepts the buffer this cycle; transfer when if_valid && d_ready
- redirect  in  1  branch taken / jump in decode; sampled only in a cycle with no transfer pending from a previous stall
- redirect_target  in  32  target address; bits [1:0] ignored

## Operation
- State machine: IDLE (no read outstanding), BUSY (read outstanding, result kept), SQUASH (read outstanding, result discarded).
- Registers: fetch_pc, last_pc (PC of the last instruction transferred to decode), pend (redirect pending), pend_tgt, buffer {if_valid, if_pc, if_instr}.
- Issue: in IDLE, if the buffer is empty or is transferring this cycle, pulse imem_req with imem_addr = fetch_pc and go to BUSY.
- Return in BUSY: load the buffer with {fetch_pc, imem_rdata} and set if_valid. Then fetch_pc <= pend ? pend_tgt : fetch_pc+4, pend <= 0, and go to IDLE.
- Return in SQUASH: drop the data, leave the buffer unchanged, go to IDLE.
- Redirect: the delay slot is last_pc+4 and is always delivered. Later sequential fetches are discarded.
  - Buffer holds the delay slot (buffer valid after the transfer): in BUSY go to SQUASH; in all states fetch_pc <= target.
  - Buffer empty, read outstanding (that read is the delay slot): pend <= 1, pend_tgt <= target.
  - Buffer empty, IDLE: fetch_pc already equals the delay slot; pend <= 1, pend_tgt <= target.
- Simultaneous return and redirect: process the return first, then evaluate the redirect against the post-return buffer state.
- Transfer and load in the same cycle: the buffer takes the new entry and if_valid stays 1.
- Address arithmetic is modulo 2^32; fetch_pc+4 wraps 0xFFFF_FFFC → 0x0000_0000.
- A second redirect while pend=1 is illegal upstream (a delay slot cannot be a branch); behavior is unspecified.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, fetch_pc=RESET_PC, last_pc=RESET_PC-4, pend=0, if_valid=0, if_pc=0, if_instr=0, imem_req=0, imem_addr=RESET_PC.
- First imem_req in the first clock edge's cycle after release.
- Reset asserted mid-read: the outstanding read is abandoned. Any imem_rvalid before the first new imem_req is ignored.
- Fetch-to-buffer latency is memory latency plus 0 cycles: data valid at edge N loads the buffer at N, and if_valid is seen in cycle N+1.
- Back-to-back throughput: one instruction per 2 cycles at 1-cycle memory latency (request, return).
- Redirect to target on imem_addr: at most 1 cycle after the delay slot returns, or after the squashed read returns.
- if_* outputs are registered. imem_req is combinational from state and the buffer handshake.

## Test plan
- Reset then 1-cycle memory, d_ready=1: imem_addr sequence 0x3000, 0x3004, 0x3008; if_pc matches each, if_valid one cycle after each rvalid.
- d_ready=0 for 5 cycles with buffer full: exactly one further read issued after the buffer empties; no instruction lost or duplicated.
- Branch at 0x3000, redirect to 0x4000 while the delay slot (0x3004) is in the buffer and 0x3008 is outstanding: 0x3008 is discarded; delivered PCs are 0x3000, 0x3004, 0x4000.
- Redirect while the delay slot is outstanding with 3-cycle latency: 0x3004 is delivered, then the next imem_addr is 0x4000.
- Redirect in the same cycle as the delay slot's rvalid: delivered PCs 0x3004 then 0x4000; no fetch of 0x3008.
- Reset asserted while a read is outstanding: outputs return to reset values immediately; the stale rvalid is ignored; fetch restarts at 0x3000.
